// File: rtl/fetch_queue.sv
// fetch_queue: PC holder and instruction-memory requester with a DEPTH-entry
// instruction/PC buffer toward decode. Credits (buffered + in-flight) bound the
// number of outstanding requests, so the buffer can never overflow. A redirect
// empties the buffer and marks every in-flight response for discard.
module fetch_queue #(
  parameter int unsigned    N        = 64,
  parameter int unsigned    IW       = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             PCBranch_F,
  input  logic                     PCSrc_F,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [N-1:0]             imem_addr_F,
  input  logic                     imem_rsp_valid,
  input  logic [IW-1:0]            imem_rsp_data,
  output logic                     instr_valid_D,
  input  logic                     instr_ready_D,
  output logic [IW-1:0]            instr_D,
  output logic [N-1:0]             pc_D,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [N-1:0] PC_INC = N'(IW / 8);

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;

  logic [IW-1:0] data_mem_q [DEPTH];
  logic [N-1:0]  pc_mem_q   [DEPTH];

  logic credit_ok;
  logic req_hs;
  logic rsp_ok;
  logic rsp_drop;
  logic push;
  logic pop;

  // Handshake qualification: credit check, response accept/discard, dequeue.
  always_comb begin
    credit_ok      = (SW'(occ_q) + SW'(outst_q)) < SW'(DEPTH);
    imem_req_valid = reset & ~PCSrc_F & credit_ok;
    req_hs         = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    rsp_ok         = imem_rsp_valid & (outst_q != '0);
    rsp_drop       = rsp_ok & ((drop_q != '0) | PCSrc_F);
    push           = rsp_ok & ~rsp_drop;
    instr_valid_D  = (occ_q != '0) & ~PCSrc_F;
    pop            = instr_valid_D & instr_ready_D;
  end

  // Next-state for PC, response-PC, credit counters and buffer pointers.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    occ_d    = occ_q;
    outst_d  = outst_q + CW'(req_hs) - CW'(rsp_ok);
    drop_d   = drop_q;
    head_d   = head_q;
    tail_d   = tail_q;

    if (PCSrc_F) begin
      pc_d     = PCBranch_F;
      rsp_pc_d = PCBranch_F;
      occ_d    = '0;
      head_d   = '0;
      tail_d   = '0;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d   = outst_q - CW'(rsp_ok);
    end else begin
      if (req_hs) begin
        pc_d = pc_q + PC_INC;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_INC;
        tail_d   = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      occ_q    <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Buffer storage; contents are only meaningful while counted by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[tail_q] <= imem_rsp_data;
      pc_mem_q[tail_q]   <= rsp_pc_q;
    end
  end

  assign imem_addr_F = pc_q;
  assign instr_D     = data_mem_q[head_q];
  assign pc_D        = pc_mem_q[head_q];
  assign occupancy   = occ_q;

  // Memory must never return more responses than were requested.
  rsp_credit_a: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: default 64-bit instance plus an 8-bit
// instance that exercises PC wrap-around.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        reset;
  logic [63:0] br_pc;
  logic        br;
  logic        req_v;
  logic        req_rdy;
  logic [63:0] addr;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic        ivalid;
  logic        irdy;
  logic [31:0] instr;
  logic [63:0] pcd;
  logic [2:0]  occ;

  // 8-bit instance
  logic        b_reset;
  logic [7:0]  b_br_pc;
  logic        b_br;
  logic        b_req_v;
  logic        b_req_rdy;
  logic [7:0]  b_addr;
  logic        b_rsp_v;
  logic [31:0] b_rsp_d;
  logic        b_ivalid;
  logic        b_irdy;
  logic [31:0] b_instr;
  logic [7:0]  b_pcd;
  logic [2:0]  b_occ;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue u_dut (
    .clk            (clk),
    .reset          (reset),
    .PCBranch_F     (br_pc),
    .PCSrc_F        (br),
    .imem_req_valid (req_v),
    .imem_req_ready (req_rdy),
    .imem_addr_F    (addr),
    .imem_rsp_valid (rsp_v),
    .imem_rsp_data  (rsp_d),
    .instr_valid_D  (ivalid),
    .instr_ready_D  (irdy),
    .instr_D        (instr),
    .pc_D           (pcd),
    .occupancy      (occ)
  );

  fetch_queue #(.N(8), .IW(32), .DEPTH(4), .RESET_PC(8'hF8)) u_dut8 (
    .clk            (clk),
    .reset          (b_reset),
    .PCBranch_F     (b_br_pc),
    .PCSrc_F        (b_br),
    .imem_req_valid (b_req_v),
    .imem_req_ready (b_req_rdy),
    .imem_addr_F    (b_addr),
    .imem_rsp_valid (b_rsp_v),
    .imem_rsp_data  (b_rsp_d),
    .instr_valid_D  (b_ivalid),
    .instr_ready_D  (b_irdy),
    .instr_D        (b_instr),
    .pc_D           (b_pcd),
    .occupancy      (b_occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [63:0] a);
    return 32'hA5A5_0000 ^ a[31:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    br      = 1'b0;
    br_pc   = '0;
    req_rdy = 1'b0;
    rsp_v   = 1'b0;
    rsp_d   = '0;
    irdy    = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  logic [63:0] t5_exp [5];
  logic        t5_rdy [5];

  initial begin
    t5_exp = '{64'h0, 64'h4, 64'h4, 64'h4, 64'h8};
    t5_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    b_reset = 1'b0; b_br = 1'b0; b_br_pc = '0; b_req_rdy = 1'b0;
    b_rsp_v = 1'b0; b_rsp_d = '0; b_irdy = 1'b0;

    // Reset state
    do_reset();
    reset = 1'b0;
    settle();
    check("rst_req_valid", 64'(req_v), 64'd0);
    check("rst_ivalid", 64'(ivalid), 64'd0);
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_addr", addr, 64'h0);
    check("rst8_addr", 64'(b_addr), 64'hF8);
    check("rst8_req_valid", 64'(b_req_v), 64'd0);

    // 1-cycle memory, decode always ready
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_rdy = 1'b1;
      irdy    = 1'b1;
      rsp_v   = (k >= 1);
      rsp_d   = (k >= 1) ? dat(64'(4 * (k - 1))) : 32'h0;
      settle();
      check("t1_req_valid", 64'(req_v), 64'd1);
      check("t1_addr", addr, 64'(4 * k));
      check("t1_ivalid", 64'(ivalid), 64'(k >= 2));
      if (k >= 2) begin
        check("t1_pc_D", pcd, 64'(4 * (k - 2)));
        check("t1_instr_D", 64'(instr), 64'(dat(64'(4 * (k - 2)))));
      end
      cyc();
    end

    // 3-cycle memory, decode stalled: credit limit of 4
    do_reset();
    for (int k = 0; k < 7; k++) begin
      req_rdy = 1'b1;
      irdy    = 1'b0;
      rsp_v   = (k >= 3);
      rsp_d   = (k >= 3) ? dat(64'(4 * (k - 3))) : 32'h0;
      settle();
      check("t2_req_valid", 64'(req_v), 64'(k <= 3));
      if (k <= 3) check("t2_addr", addr, 64'(4 * k));
      check("t2_occ", 64'(occ), 64'((k > 3) ? (k - 3) : 0));
      cyc();
    end
    rsp_v = 1'b0;
    irdy  = 1'b1;
    settle();
    check("t2_full_req_valid", 64'(req_v), 64'd0);
    check("t2_full_occ", 64'(occ), 64'd4);
    check("t2_full_ivalid", 64'(ivalid), 64'd1);
    check("t2_head_pc", pcd, 64'h0);
    check("t2_head_instr", 64'(instr), 64'(dat(64'h0)));
    cyc();
    irdy = 1'b0;
    settle();
    check("t2_refill_req_valid", 64'(req_v), 64'd1);
    check("t2_refill_addr", addr, 64'h10);
    check("t2_next_pc", pcd, 64'h4);
    check("t2_occ_after_pop", 64'(occ), 64'd3);
    cyc();
    settle();
    check("t2_single_refill", 64'(req_v), 64'd0);
    check("t2_addr_after_refill", addr, 64'h14);

    // Redirect with two requests in flight
    do_reset();
    req_rdy = 1'b1;
    irdy    = 1'b1;
    settle();
    check("t3_addr0", addr, 64'h0);
    cyc();
    settle();
    check("t3_addr1", addr, 64'h4);
    cyc();
    br = 1'b1; br_pc = 64'h100;
    settle();
    check("t3_redirect_req_valid", 64'(req_v), 64'd0);
    check("t3_redirect_ivalid", 64'(ivalid), 64'd0);
    cyc();
    br = 1'b0; rsp_v = 1'b1; rsp_d = 32'hDEAD_0000;
    settle();
    check("t3_new_req_valid", 64'(req_v), 64'd1);
    check("t3_new_addr", addr, 64'h100);
    cyc();
    rsp_d = 32'hDEAD_0004;
    settle();
    check("t3_addr_104", addr, 64'h104);
    check("t3_stale1_dropped", 64'(ivalid), 64'd0);
    cyc();
    rsp_d = dat(64'h100);
    settle();
    check("t3_stale2_dropped", 64'(ivalid), 64'd0);
    check("t3_occ_empty", 64'(occ), 64'd0);
    check("t3_addr_108", addr, 64'h108);
    cyc();
    rsp_v = 1'b0; req_rdy = 1'b0;
    settle();
    check("t3_first_ivalid", 64'(ivalid), 64'd1);
    check("t3_first_pc", pcd, 64'h100);
    check("t3_first_instr", 64'(instr), 64'(dat(64'h100)));
    check("t3_occ_one", 64'(occ), 64'd1);
    // Asynchronous reset mid-stream
    reset = 1'b0;
    settle();
    check("t3_arst_req_valid", 64'(req_v), 64'd0);
    check("t3_arst_ivalid", 64'(ivalid), 64'd0);
    check("t3_arst_occ", 64'(occ), 64'd0);
    check("t3_arst_addr", addr, 64'h0);

    // Redirect coinciding with a response and a would-be pop (2-cycle memory)
    do_reset();
    req_rdy = 1'b1;
    irdy    = 1'b1;
    settle();
    check("t4_addr0", addr, 64'h0);
    cyc();
    settle();
    check("t4_addr1", addr, 64'h4);
    cyc();
    rsp_v = 1'b1; rsp_d = dat(64'h0);
    settle();
    check("t4_addr2", addr, 64'h8);
    check("t4_ivalid_c2", 64'(ivalid), 64'd0);
    cyc();
    rsp_v = 1'b1; rsp_d = dat(64'h4); br = 1'b1; br_pc = 64'h200;
    settle();
    check("t4_redirect_req_valid", 64'(req_v), 64'd0);
    check("t4_redirect_no_pop", 64'(ivalid), 64'd0);
    check("t4_occ_before", 64'(occ), 64'd1);
    cyc();
    br = 1'b0; rsp_v = 1'b1; rsp_d = dat(64'h8);
    settle();
    check("t4_occ_cleared", 64'(occ), 64'd0);
    check("t4_ivalid_cleared", 64'(ivalid), 64'd0);
    check("t4_req_valid", 64'(req_v), 64'd1);
    check("t4_new_addr", addr, 64'h200);
    cyc();
    rsp_v = 1'b0;
    settle();
    check("t4_stale_dropped", 64'(ivalid), 64'd0);
    check("t4_addr_204", addr, 64'h204);
    cyc();
    rsp_v = 1'b1; rsp_d = dat(64'h200);
    settle();
    check("t4_ivalid_c6", 64'(ivalid), 64'd0);
    cyc();
    rsp_v = 1'b1; rsp_d = dat(64'h204);
    settle();
    check("t4_first_ivalid", 64'(ivalid), 64'd1);
    check("t4_first_pc", pcd, 64'h200);
    check("t4_first_instr", 64'(instr), 64'(dat(64'h200)));
    cyc();
    rsp_v = 1'b0;
    settle();
    check("t4_second_pc", pcd, 64'h204);
    check("t4_second_instr", 64'(instr), 64'(dat(64'h204)));

    // Request-ready toggling: PC moves only on handshakes
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_rdy = t5_rdy[k];
      settle();
      check("t5_req_valid", 64'(req_v), 64'd1);
      check("t5_addr", addr, t5_exp[k]);
      cyc();
    end

    // 8-bit PC wrap from 0xF8
    b_reset   = 1'b1;
    b_req_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t6_req_valid", 64'(b_req_v), 64'(k < 4));
      check("t6_addr", 64'(b_addr), 64'(8'(8'hF8 + 8'(4 * k))));
      cyc();
    end
    check("t6_occ", 64'(b_occ), 64'd0);
    check("t6_ivalid", 64'(b_ivalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
